// File: rtl/control_fsm.sv
// Multicycle control unit for the IF674 MIPS subset: drives every datapath enable and mux select.
// Outputs decode from state (funct in R-type, alu_zero in branches); no backpressure, memory is 1-cycle.
module control_fsm #(
    parameter logic [4:0]  RESET_STATE = 5'd0,
    parameter logic [31:0] VEC_OPCODE  = 32'd253,
    parameter logic [31:0] VEC_OVF     = 32'd254
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] iord,
    output logic [1:0] error_sel,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       epc_write,
    output logic       reg_write,
    output logic [2:0] reg_dst,
    output logic [3:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [4:0] state_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_LOADA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_CMP   = 3'b111;

    // Encodings are offsets from RESET_STATE so any reset encoding stays collision-free.
    typedef enum logic [4:0] {
        S_RESET      = RESET_STATE,
        S_FETCH      = RESET_STATE + 5'd1,
        S_FETCH_WAIT = RESET_STATE + 5'd2,
        S_DECODE     = RESET_STATE + 5'd3,
        S_R_EXEC     = RESET_STATE + 5'd4,
        S_R_WB       = RESET_STATE + 5'd5,
        S_ADDI_EXEC  = RESET_STATE + 5'd6,
        S_ADDI_WB    = RESET_STATE + 5'd7,
        S_MEM_ADDR   = RESET_STATE + 5'd8,
        S_LW_READ    = RESET_STATE + 5'd9,
        S_LW_WAIT    = RESET_STATE + 5'd10,
        S_LW_WB      = RESET_STATE + 5'd11,
        S_SW_WRITE   = RESET_STATE + 5'd12,
        S_BEQ        = RESET_STATE + 5'd13,
        S_BNE        = RESET_STATE + 5'd14,
        S_J          = RESET_STATE + 5'd15,
        S_JAL        = RESET_STATE + 5'd16,
        S_JR         = RESET_STATE + 5'd17,
        S_EXC_EPC    = RESET_STATE + 5'd18,
        S_EXC_READ   = RESET_STATE + 5'd19,
        S_EXC_WAIT   = RESET_STATE + 5'd20,
        S_EXC_LOAD   = RESET_STATE + 5'd21
    } state_t;

    state_t state;
    logic   cause;
    logic   fn_arith;
    logic   fn_alu;
    logic   unused_vec;

    assign fn_arith = (funct == FN_ADD) || (funct == FN_SUB);
    assign fn_alu   = fn_arith || (funct == FN_AND) || (funct == FN_SLT);

    // The handler addresses live in the datapath's error mux; error_sel picks between them.
    assign unused_vec = ^{VEC_OPCODE, VEC_OVF};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
            cause <= 1'b0;
        end else begin
            case (state)
                S_RESET:      state <= S_FETCH;
                S_FETCH:      state <= S_FETCH_WAIT;
                S_FETCH_WAIT: state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (fn_alu) begin
                                state <= S_R_EXEC;
                            end else if (funct == FN_JR) begin
                                state <= S_JR;
                            end else begin
                                state <= S_EXC_EPC;
                                cause <= 1'b0;
                            end
                        end
                        OP_ADDI:      state <= S_ADDI_EXEC;
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_BEQ:       state <= S_BEQ;
                        OP_BNE:       state <= S_BNE;
                        OP_J:         state <= S_J;
                        OP_JAL:       state <= S_JAL;
                        default: begin
                            state <= S_EXC_EPC;
                            cause <= 1'b0;
                        end
                    endcase
                end
                S_R_EXEC: begin
                    // and/slt cannot trap, so overflow only matters for add/sub.
                    if (fn_arith && alu_overflow) begin
                        state <= S_EXC_EPC;
                        cause <= 1'b1;
                    end else begin
                        state <= S_R_WB;
                    end
                end
                S_ADDI_EXEC: begin
                    if (alu_overflow) begin
                        state <= S_EXC_EPC;
                        cause <= 1'b1;
                    end else begin
                        state <= S_ADDI_WB;
                    end
                end
                S_MEM_ADDR:   state <= (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
                S_LW_READ:    state <= S_LW_WAIT;
                S_LW_WAIT:    state <= S_LW_WB;
                S_EXC_EPC:    state <= S_EXC_READ;
                S_EXC_READ:   state <= S_EXC_WAIT;
                S_EXC_WAIT:   state <= S_EXC_LOAD;
                S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE, S_BEQ, S_BNE,
                S_J, S_JAL, S_JR, S_EXC_LOAD: state <= S_FETCH;
                default:      state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        iord         = 2'd0;
        error_sel    = 2'd0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        aluout_write = 1'b0;
        epc_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 3'd0;
        mem_to_reg   = 4'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = ALU_LOADA;
        state_out    = state;
        case (state)
            S_FETCH: begin
                alu_src_b = 2'd1;
                alu_op    = ALU_ADD;
                pc_write  = 1'b1;
            end
            S_FETCH_WAIT: ir_write = 1'b1;
            S_DECODE: begin
                a_write      = 1'b1;
                b_write      = 1'b1;
                alu_src_b    = 2'd3;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                aluout_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_SLT:  alu_op = ALU_CMP;
                    default: alu_op = ALU_LOADA;
                endcase
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 3'd1;
                mem_to_reg = (funct == FN_SLT) ? 4'd5 : 4'd1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 4'd1;
            end
            S_LW_READ: iord = 2'd2;
            S_LW_WAIT: mdr_write = 1'b1;
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 4'd4;
            end
            S_SW_WRITE: begin
                iord      = 2'd2;
                mem_write = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_write  = (state == S_BEQ) ? alu_zero : !alu_zero;
            end
            S_J: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = 3'd2;
                mem_to_reg = 4'd8;
                pc_src     = 2'd2;
                pc_write   = 1'b1;
            end
            S_JR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_LOADA;
                pc_write  = 1'b1;
            end
            S_EXC_EPC: begin
                alu_src_b = 2'd1;
                alu_op    = ALU_SUB;
                epc_write = 1'b1;
                error_sel = {1'b0, cause};
            end
            S_EXC_READ: begin
                iord      = 2'd1;
                error_sel = {1'b0, cause};
            end
            S_EXC_WAIT: error_sel = {1'b0, cause};
            S_EXC_LOAD: begin
                pc_src    = 2'd3;
                pc_write  = 1'b1;
                error_sel = {1'b0, cause};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: a driver pushes per-cycle expected controls, a monitor checks them.
module tb_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] iord;
        logic [1:0] error_sel;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       aluout_write;
        logic       epc_write;
        logic       reg_write;
        logic [2:0] reg_dst;
        logic [3:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctl_t;

    typedef struct {
        ctl_t ctl;
        bit   rst_chk;
        int   id;
        int   tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       alu_overflow = 1'b0;
    logic       alu_zero = 1'b0;
    logic       pc_write, mem_write, ir_write, mdr_write, a_write, b_write;
    logic       aluout_write, epc_write, reg_write, alu_src_a;
    logic [1:0] pc_src, iord, error_sel, alu_src_b;
    logic [2:0] reg_dst, alu_op;
    logic [3:0] mem_to_reg;
    logic [4:0] state_out;

    control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .error_sel(error_sel),
        .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .a_write(a_write), .b_write(b_write), .aluout_write(aluout_write),
        .epc_write(epc_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc_id = 0;
    int   cur_tag = 0;
    int   ovf_mode = 2;
    int   zero_mode = 2;

    logic [5:0] op_tab [0:11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B,
                                  6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h11};
    logic [5:0] fn_tab [0:7]  = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h08, 6'h20, 6'h00, 6'h25};

    task automatic set_flags();
        alu_overflow = (ovf_mode == 2) ? ($urandom_range(0, 2) == 0) : (ovf_mode == 1);
        alu_zero     = (zero_mode == 2) ? $urandom_range(0, 1) : (zero_mode == 1);
    endtask

    // One cycle: queue what the DUT must show now, then move to the next cycle.
    task automatic emit(input ctl_t c, input bit rc);
        exp_t e;
        e.ctl = c;
        e.rst_chk = rc;
        e.id = cyc_id;
        e.tag = cur_tag;
        cyc_id = cyc_id + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        set_flags();
    endtask

    function automatic ctl_t alu_cfg(input bit a, input logic [1:0] b, input logic [2:0] op);
        ctl_t c;
        c = '0;
        c.alu_src_a = a;
        c.alu_src_b = b;
        c.alu_op = op;
        return c;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) emit('0, 1'b1);
        rst = 1'b0;
        emit('0, 1'b1);
    endtask

    task automatic exc(input bit sel);
        ctl_t c;
        c = alu_cfg(1'b0, 2'd1, 3'b010);
        c.epc_write = 1'b1;
        c.error_sel = {1'b0, sel};
        emit(c, 1'b0);
        c = '0; c.iord = 2'd1; c.error_sel = {1'b0, sel};
        emit(c, 1'b0);
        c = '0; c.error_sel = {1'b0, sel};
        emit(c, 1'b0);
        c = '0; c.pc_src = 2'd3; c.pc_write = 1'b1; c.error_sel = {1'b0, sel};
        emit(c, 1'b0);
    endtask

    task automatic fetch_decode();
        ctl_t c;
        c = alu_cfg(1'b0, 2'd1, 3'b001);
        c.pc_write = 1'b1;
        emit(c, 1'b0);
        c = '0; c.ir_write = 1'b1;
        emit(c, 1'b0);
        c = alu_cfg(1'b0, 2'd3, 3'b001);
        c.a_write = 1'b1; c.b_write = 1'b1; c.aluout_write = 1'b1;
        emit(c, 1'b0);
    endtask

    // Reference: instruction class -> per-cycle control sequence, straight from the ISA table.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_after);
        ctl_t c;
        bit   trap;
        opcode = op;
        funct = fn;
        set_flags();
        fetch_decode();
        case (op)
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h2A) begin
                    trap = alu_overflow && (fn == 6'h20 || fn == 6'h22);
                    c = alu_cfg(1'b1, 2'd0, fn == 6'h20 ? 3'b001 : fn == 6'h22 ? 3'b010 :
                                            fn == 6'h24 ? 3'b011 : 3'b111);
                    c.aluout_write = 1'b1;
                    emit(c, 1'b0);
                    if (trap) exc(1'b1);
                    else begin
                        c = '0; c.reg_write = 1'b1; c.reg_dst = 3'd1;
                        c.mem_to_reg = (fn == 6'h2A) ? 4'd5 : 4'd1;
                        emit(c, 1'b0);
                    end
                end else if (fn == 6'h08) begin
                    c = alu_cfg(1'b1, 2'd0, 3'b000);
                    c.pc_write = 1'b1;
                    emit(c, 1'b0);
                end else exc(1'b0);
            end
            6'h08: begin
                trap = alu_overflow;
                c = alu_cfg(1'b1, 2'd2, 3'b001);
                c.aluout_write = 1'b1;
                emit(c, 1'b0);
                if (trap) exc(1'b1);
                else begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 4'd1;
                    emit(c, 1'b0);
                end
            end
            6'h23, 6'h2B: begin
                c = alu_cfg(1'b1, 2'd2, 3'b001);
                c.aluout_write = 1'b1;
                emit(c, 1'b0);
                c = '0; c.iord = 2'd2; c.mem_write = (op == 6'h2B);
                emit(c, 1'b0);
                if (op == 6'h23) begin
                    if (abort_after == 5) begin
                        do_reset(2);
                        return;
                    end
                    c = '0; c.mdr_write = 1'b1;
                    emit(c, 1'b0);
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 4'd4;
                    emit(c, 1'b0);
                end
            end
            6'h04, 6'h05: begin
                c = alu_cfg(1'b1, 2'd0, 3'b010);
                c.pc_src = 2'd1;
                c.pc_write = (op == 6'h04) ? alu_zero : !alu_zero;
                emit(c, 1'b0);
            end
            6'h02, 6'h03: begin
                c = '0; c.pc_src = 2'd2; c.pc_write = 1'b1;
                if (op == 6'h03) begin
                    c.reg_write = 1'b1; c.reg_dst = 3'd2; c.mem_to_reg = 4'd8;
                end
                emit(c, 1'b0);
            end
            default: exc(1'b0);
        endcase
    endtask

    // Monitor: pops one expectation per cycle and compares at the falling edge.
    initial begin
        exp_t e;
        ctl_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pc_write, pc_src, iord, error_sel, mem_write, ir_write, mdr_write,
                       a_write, b_write, aluout_write, epc_write, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, alu_op};
                n_tests = n_tests + 1;
                if (got !== e.ctl) begin
                    n_fail = n_fail + 1;
                    $display("FAIL ctl cycle=%0d test=%0d got=%h expected=%h", e.id, e.tag, got, e.ctl);
                end
                if (e.rst_chk) begin
                    n_tests = n_tests + 1;
                    if (state_out !== 5'd0) begin
                        n_fail = n_fail + 1;
                        $display("FAIL reset_state cycle=%0d got=%0d expected=0", e.id, state_out);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_flags();
        @(posedge clk);
        #1;
        do_reset(2);

        cur_tag = 1; ovf_mode = 2; run_instr(6'h23, 6'h00, 5);
        cur_tag = 2; ovf_mode = 0; run_instr(6'h00, 6'h20, 0);
        cur_tag = 3; ovf_mode = 1; run_instr(6'h08, 6'h00, 0);
        cur_tag = 4; ovf_mode = 1; run_instr(6'h23, 6'h00, 0);
        cur_tag = 5; ovf_mode = 1; run_instr(6'h00, 6'h24, 0);
        cur_tag = 6; ovf_mode = 1; run_instr(6'h00, 6'h22, 0);
        cur_tag = 7; ovf_mode = 2; zero_mode = 1; run_instr(6'h04, 6'h00, 0);
        cur_tag = 8; run_instr(6'h05, 6'h00, 0);
        cur_tag = 9; zero_mode = 2; run_instr(6'h3F, 6'h00, 0);
        cur_tag = 10; run_instr(6'h03, 6'h00, 0);
        cur_tag = 11; run_instr(6'h2B, 6'h00, 0);

        ovf_mode = 2;
        zero_mode = 2;
        for (int i = 0; i < 400; i++) begin
            cur_tag = 100 + i;
            run_instr(op_tab[$urandom_range(0, 11)], fn_tab[$urandom_range(0, 7)], 0);
            if ($urandom_range(0, 49) == 0) do_reset(1);
        end

        @(negedge clk);
        #1;
        n_tests = n_tests + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
